axi_wr_slave_mem: RTL



---
 rtl/axi_wr_slave_mem_if.sv | 47 ++++
 rtl/axi_wr_slave_mem.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_slave_mem_if.sv
// AXI4 write-channel bundle (AW, W and B) used by axi_wr_slave_mem.
// The slave modport is the responder view; the master modport is the
// initiator view used by VIP/bench code.
interface axi_wr_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8
);
    // Write address channel
    logic [ID_WIDTH-1:0]     AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [LEN_WIDTH-1:0]    AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;
    // Write data channel
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;
    // Write response channel
    logic [ID_WIDTH-1:0]     BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );
endinterface

// File: rtl/axi_wr_slave_mem.sv
// AXI4 write-channel responder backed by a word-addressed memory.
// One burst in flight: AW accept -> W beats -> single B response -> idle.
// Beats carry byte strobes; a combinational backdoor port reads the memory.
// DATA_WIDTH must be 32 or 64; MEM_DEPTH must be a power of two.
// Optional: define AXI_WR_SLAVE_WRAP_EN to support WRAP bursts; without it
// a WRAP burst is absorbed without writing and answered with SLVERR.
module axi_wr_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    axi_wr_slave_mem_if.slave            axi,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_rd_addr,
    output logic [DATA_WIDTH-1:0]        mem_rd_data
);
    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned LOG2B    = $clog2(STRB_W);
    localparam int unsigned MEM_AW   = $clog2(MEM_DEPTH);
    localparam logic [2:0]  MAX_SIZE = 3'(LOG2B);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_RESP
    } state_t;

    state_t                state_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic [ID_WIDTH-1:0]   bid_q;
    logic [1:0]            bresp_q;

    // Latched burst attributes
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  err_q;
    logic                  err_d;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                  aw_fire;
    logic                  w_fire;
    logic                  is_last;
    logic                  beat_oob;
    logic                  aw_err;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] beat_inc;
    logic [MEM_AW-1:0]     beat_idx;

    assign aw_fire  = (state_q == S_IDLE) && awready_q && axi.AWVALID;
    assign w_fire   = (state_q == S_DATA) && wready_q && axi.WVALID;
    assign is_last  = (cnt_q == len_q);
    assign beat_idx = addr_q[LOG2B +: MEM_AW];
    assign beat_oob = (addr_q >> (LOG2B + MEM_AW)) != '0;
    assign mem_we   = w_fire && !err_q && !beat_oob;
    assign beat_inc = ADDR_WIDTH'(1) << size_q;

`ifdef AXI_WR_SLAVE_WRAP_EN
    logic [ADDR_WIDTH-1:0] aw_inc;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    assign aw_inc    = ADDR_WIDTH'(1) << axi.AWSIZE;
    assign wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
`endif

    // Classify the incoming AW request; errors found here suppress all writes.
    always_comb begin
        aw_err = (axi.AWSIZE > MAX_SIZE) || (axi.AWBURST == 2'b11);
`ifdef AXI_WR_SLAVE_WRAP_EN
        if (axi.AWBURST == 2'b10) begin
            if (!((axi.AWLEN == LEN_WIDTH'(1)) || (axi.AWLEN == LEN_WIDTH'(3)) ||
                  (axi.AWLEN == LEN_WIDTH'(7)) || (axi.AWLEN == LEN_WIDTH'(15)))) begin
                aw_err = 1'b1;
            end
            if ((axi.AWADDR & (aw_inc - ADDR_WIDTH'(1))) != '0) begin
                aw_err = 1'b1;
            end
        end
`else
        if (axi.AWBURST == 2'b10) begin
            aw_err = 1'b1;
        end
`endif
    end

    // Address of the next beat and the error flag after the current beat.
    always_comb begin
        addr_d = addr_q;
        case (burst_q)
            2'b01: addr_d = addr_q + beat_inc;
`ifdef AXI_WR_SLAVE_WRAP_EN
            // Wrap size is a power of two and base is aligned to it, so
            // base + ((addr - base + inc) mod size) reduces to OR-ing the
            // aligned base with the masked incremented address.
            2'b10: addr_d = (addr_q & ~wrap_mask) | ((addr_q + beat_inc) & wrap_mask);
`endif
            default: addr_d = addr_q;
        endcase
        err_d = err_q || beat_oob || (axi.WLAST != is_last);
    end

    // Burst sequencer: IDLE accepts AW, DATA absorbs beats, RESP holds B.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= S_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= 2'b00;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    awready_q <= 1'b1;
                    if (aw_fire) begin
                        id_q      <= axi.AWID;
                        addr_q    <= axi.AWADDR;
                        len_q     <= axi.AWLEN;
                        size_q    <= axi.AWSIZE;
                        burst_q   <= axi.AWBURST;
                        err_q     <= aw_err;
                        cnt_q     <= '0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_fire) begin
                        cnt_q  <= cnt_q + LEN_WIDTH'(1);
                        addr_q <= addr_d;
                        err_q  <= err_d;
                        if (is_last) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= id_q;
                            bresp_q  <= err_d ? 2'b10 : 2'b00;
                            state_q  <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (axi.BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Byte-lane write into the backing store; contents survive reset.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (axi.WSTRB[b]) begin
                    mem_q[beat_idx][8*b +: 8] <= axi.WDATA[8*b +: 8];
                end
            end
        end
    end

    assign mem_rd_data = mem_q[mem_rd_addr];

    assign axi.AWREADY = awready_q;
    assign axi.WREADY  = wready_q;
    assign axi.BVALID  = bvalid_q;
    assign axi.BID     = bid_q;
    assign axi.BRESP   = bresp_q;
endmodule
